// File: rtl/arbiter_pkg.sv
// Shared definitions for the PE bus arbiter: FSM state encoding and the
// default array sizing used by both the arbiter and the top-level PE array.
// No logic; types and constants only.
package arbiter_pkg;

    // Default array sizing, shared with the PE array top level.
    localparam int DEFAULT_N_PE     = 4;
    localparam int DEFAULT_MAX_HOLD = 16;

    // Arbiter FSM states. The encoding is fixed so that debug tools and the
    // PE array can decode the state register directly.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin priority picker: finds the first set request bit at or above
// `start`, wrapping from N_PE-1 to 0. Purely combinational.
// Ports: request (N_PE) and start (IDW) in; winner (IDW) and any out.
module rr_priority_picker
    import arbiter_pkg::*;
#(
    parameter int N_PE = DEFAULT_N_PE,
    parameter int IDW  = $clog2(N_PE)
) (
    input  logic [N_PE-1:0] request,
    input  logic [IDW-1:0]  start,
    output logic [IDW-1:0]  winner,
    output logic            any
);

    localparam logic [IDW:0] N_PE_W = (IDW+1)'(N_PE);

    logic [2*N_PE-1:0] dbl;
    logic [N_PE-1:0]   rot;
    logic [IDW-1:0]    off;
    logic [IDW:0]      sum;

    // Rotate the request vector so bit j holds request[(start+j) mod N_PE];
    // the winner is then the lowest set bit, offset back by `start`.
    assign dbl = {request, request} >> start;
    assign rot = dbl[N_PE-1:0];
    assign any = |rot;

    always_comb begin
        off = '0;
        // Scan from the top down so the lowest set offset is written last.
        for (int i = N_PE - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = IDW'(i);
            end
        end
    end

    always_comb begin
        sum = {1'b0, start} + {1'b0, off};
        if (sum >= N_PE_W) begin
            sum = sum - N_PE_W;
        end
    end

    assign winner = sum[IDW-1:0];

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner of the shared PE bus with a one-cycle turnaround gap
// between owners and a bounded hold time when other PEs are waiting.
// Ports: clk, reset (sync, active-high), bus_request in; grant, grant_id,
// bus_busy, preempt out (all registered).
module bus_arbiter
    import arbiter_pkg::*;
#(
    parameter int N_PE     = DEFAULT_N_PE,
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
    parameter int IDW      = $clog2(N_PE)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_PE-1:0] bus_request,
    output logic [N_PE-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            bus_busy,
    output logic            preempt
);

    localparam int           HCW       = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(MAX_HOLD - 1);
    localparam logic [IDW:0] N_PE_W    = (IDW+1)'(N_PE);

    arb_state_t      state, state_nxt;
    logic [IDW-1:0]  ptr, ptr_nxt;
    logic [IDW-1:0]  owner, owner_nxt;
    logic [HCW-1:0]  hold_cnt, hold_nxt;
    logic            preempt_nxt;

    logic [IDW:0]    owner_p1;
    logic [IDW-1:0]  owner_inc;
    logic [N_PE-1:0] owner_oh;
    logic            others_waiting;
    logic [IDW-1:0]  pick_start;
    logic [IDW-1:0]  pick_winner;
    logic            pick_any;

    // (owner + 1) mod N_PE; N_PE need not be a power of two.
    assign owner_p1  = {1'b0, owner} + (IDW+1)'(1);
    assign owner_inc = (owner_p1 == N_PE_W) ? '0 : owner_p1[IDW-1:0];

    assign owner_oh       = N_PE'(1) << owner;
    assign others_waiting = |(bus_request & ~owner_oh);

    // The RELEASE cycle arbitrates with the pointer value it is about to
    // commit, so the outgoing owner is already at lowest priority.
    assign pick_start = (state == ST_RELEASE) ? owner_inc : ptr;

    rr_priority_picker #(
        .N_PE (N_PE),
        .IDW  (IDW)
    ) u_picker (
        .request (bus_request),
        .start   (pick_start),
        .winner  (pick_winner),
        .any     (pick_any)
    );

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        owner_nxt   = owner;
        hold_nxt    = hold_cnt;
        preempt_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    state_nxt = ST_GRANT;
                    owner_nxt = pick_winner;
                    hold_nxt  = '0;
                end
            end
            ST_GRANT: begin
                if (hold_cnt != HOLD_LAST) begin
                    hold_nxt = hold_cnt + HCW'(1);
                end
                // A voluntary release wins over a simultaneous timeout, so
                // preempt only fires when the owner still wants the bus.
                if (!bus_request[owner]) begin
                    state_nxt = ST_RELEASE;
                end else if (hold_cnt == HOLD_LAST && others_waiting) begin
                    state_nxt   = ST_RELEASE;
                    preempt_nxt = 1'b1;
                end
            end
            ST_RELEASE: begin
                ptr_nxt = owner_inc;
                if (pick_any) begin
                    state_nxt = ST_GRANT;
                    owner_nxt = pick_winner;
                    hold_nxt  = '0;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            owner    <= '0;
            hold_cnt <= '0;
            grant    <= '0;
            grant_id <= '0;
            bus_busy <= 1'b0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
            hold_cnt <= hold_nxt;
            // Outputs are registered copies of the decode of the next state,
            // so they always match the state/owner registers.
            grant    <= (state_nxt == ST_GRANT) ? (N_PE'(1) << owner_nxt) : '0;
            grant_id <= owner_nxt;
            bus_busy <= (state_nxt == ST_GRANT);
            preempt  <= preempt_nxt;
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter (N_PE=4, MAX_HOLD=4): a table of per-cycle
// {inputs, expected outputs} records plus hand-written multi-cycle sequences.
// Inputs change on the falling edge; outputs are checked 1 ns after the rising edge.
module tb_bus_arbiter;

    localparam int N   = 4;
    localparam int MH  = 4;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   bus_request;
    logic [N-1:0]   grant;
    logic [IDW-1:0] grant_id;
    logic           bus_busy;
    logic           preempt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_arbiter #(
        .N_PE     (N),
        .MAX_HOLD (MH),
        .IDW      (IDW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_request (bus_request),
        .grant       (grant),
        .grant_id    (grant_id),
        .bus_busy    (bus_busy),
        .preempt     (preempt)
    );

    typedef struct {
        logic [N-1:0]   req;
        logic           rst;
        logic [N-1:0]   g;
        logic           b;
        logic [IDW-1:0] id;
        logic           cid;
        logic           p;
    } vec_t;

    vec_t vecs[$];

    // Expected outputs describe the state right after the edge that samples
    // req/rst. grant_id is only compared where cid is set.
    task automatic add(input logic [N-1:0] req, input logic rst, input logic [N-1:0] g,
                       input logic b, input logic [IDW-1:0] id, input logic cid, input logic p);
        vec_t v;
        v.req = req; v.rst = rst; v.g = g; v.b = b; v.id = id; v.cid = cid; v.p = p;
        vecs.push_back(v);
    endtask

    task automatic chk1(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h, expected %0h", nm, idx, act, exp);
        end
    endtask

    task automatic step(input string nm, input int idx, input vec_t v);
        @(negedge clk);
        bus_request = v.req;
        reset       = v.rst;
        @(posedge clk);
        #1;
        chk1({nm, ".grant"},   idx, 32'(grant),    32'(v.g));
        chk1({nm, ".busy"},    idx, 32'(bus_busy), 32'(v.b));
        chk1({nm, ".preempt"}, idx, 32'(preempt),  32'(v.p));
        if (v.cid) chk1({nm, ".grant_id"}, idx, 32'(grant_id), 32'(v.id));
    endtask

    task automatic go(input string nm, input logic [N-1:0] req, input logic rst,
                      input logic [N-1:0] g, input logic b, input logic [IDW-1:0] id,
                      input logic cid, input logic p);
        vec_t v;
        v.req = req; v.rst = rst; v.g = g; v.b = b; v.id = id; v.cid = cid; v.p = p;
        step(nm, 0, v);
    endtask

    initial begin
        reset       = 1'b1;
        bus_request = '0;

        // Reset state.
        add(4'b0000, 1, 4'b0000, 0, 2'd0, 1, 0);
        add(4'b0000, 1, 4'b0000, 0, 2'd0, 1, 0);
        // Single requester PE2: grant on the sampling edge, release one edge
        // after the drop, then ptr=3 makes PE3 beat PE0.
        add(4'b0000, 0, 4'b0000, 0, 2'd0, 0, 0);
        add(4'b0100, 0, 4'b0100, 1, 2'd2, 1, 0);
        add(4'b0100, 0, 4'b0100, 1, 2'd2, 1, 0);
        add(4'b0100, 0, 4'b0100, 1, 2'd2, 1, 0);
        add(4'b0100, 0, 4'b0100, 1, 2'd2, 1, 0);
        add(4'b0000, 0, 4'b0000, 0, 2'd0, 0, 0);
        add(4'b0000, 0, 4'b0000, 0, 2'd0, 0, 0);
        add(4'b1001, 0, 4'b1000, 1, 2'd3, 1, 0);
        add(4'b0000, 0, 4'b0000, 0, 2'd0, 0, 0);
        add(4'b0000, 0, 4'b0000, 0, 2'd0, 0, 0);
        // Everyone requesting, ptr=0: each owner drops after 3 grant cycles
        // and re-requests; one-cycle gap between owners.
        for (int k = 0; k < 4; k++) begin
            logic [N-1:0] oh;
            oh = N'(1) << k;
            add(4'b1111, 0, oh, 1, IDW'(k), 1, 0);
            add(4'b1111, 0, oh, 1, IDW'(k), 1, 0);
            add(4'b1111, 0, oh, 1, IDW'(k), 1, 0);
            add(4'b1111 & ~oh, 0, 4'b0000, 0, 2'd0, 0, 0);
        end
        add(4'b1111, 0, 4'b0001, 1, 2'd0, 1, 0);
        add(4'b0000, 0, 4'b0000, 0, 2'd0, 0, 0);
        add(4'b0000, 0, 4'b0000, 0, 2'd0, 0, 0);
        // ptr=1. PE1 and PE2 contend: 4 cycles each, preempt pulse in the gap.
        for (int k = 0; k < 4; k++) add(4'b0110, 0, 4'b0010, 1, 2'd1, 1, 0);
        add(4'b0110, 0, 4'b0000, 0, 2'd0, 0, 1);
        for (int k = 0; k < 4; k++) add(4'b0110, 0, 4'b0100, 1, 2'd2, 1, 0);
        add(4'b0110, 0, 4'b0000, 0, 2'd0, 0, 1);
        add(4'b0110, 0, 4'b0010, 1, 2'd1, 1, 0);
        add(4'b0000, 0, 4'b0000, 0, 2'd0, 0, 0);
        add(4'b0000, 0, 4'b0000, 0, 2'd0, 0, 0);
        // ptr=2. PE0 owns, PE2 waits, PE0 drops exactly when its hold count
        // reaches MAX_HOLD-1: release without preempt, then PE2.
        add(4'b0001, 0, 4'b0001, 1, 2'd0, 1, 0);
        add(4'b0101, 0, 4'b0001, 1, 2'd0, 1, 0);
        add(4'b0101, 0, 4'b0001, 1, 2'd0, 1, 0);
        add(4'b0101, 0, 4'b0001, 1, 2'd0, 1, 0);
        add(4'b0100, 0, 4'b0000, 0, 2'd0, 0, 0);
        add(4'b0100, 0, 4'b0100, 1, 2'd2, 1, 0);
        add(4'b0000, 0, 4'b0000, 0, 2'd0, 0, 0);
        add(4'b0000, 0, 4'b0000, 0, 2'd0, 0, 0);

        foreach (vecs[i]) step("vec", i, vecs[i]);

        // ptr=3. Lone PE3 keeps the grant for 20 cycles with no preempt.
        for (int k = 0; k < 20; k++) go("lone_pe3", 4'b1000, 0, 4'b1000, 1, 2'd3, 1, 0);
        go("lone_pe3_rel", 4'b0000, 0, 4'b0000, 0, 2'd0, 0, 0);
        go("lone_pe3_idle", 4'b0000, 0, 4'b0000, 0, 2'd0, 0, 0);

        // ptr=0. Move ptr to 2 via a PE1 ownership, then reset while PE2 owns
        // with all PEs requesting: after reset, ptr=0 so PE0 wins.
        go("rst_pe1", 4'b0010, 0, 4'b0010, 1, 2'd1, 1, 0);
        go("rst_pe1_rel", 4'b0000, 0, 4'b0000, 0, 2'd0, 0, 0);
        go("rst_idle", 4'b0000, 0, 4'b0000, 0, 2'd0, 0, 0);
        go("rst_pe2", 4'b0100, 0, 4'b0100, 1, 2'd2, 1, 0);
        go("rst_pe2_all", 4'b1111, 0, 4'b0100, 1, 2'd2, 1, 0);
        go("rst_hit", 4'b1111, 1, 4'b0000, 0, 2'd0, 1, 0);
        go("rst_resume", 4'b1111, 0, 4'b0001, 1, 2'd0, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that owns the shared PE bus: it samples the `bus_request` line of every PE_system tile and returns a one-hot `grant` that each tile's bus interface uses to drive the global/local memory bus. It sits directly upstream of the PE tiles' `grant` inputs. It enforces a one-cycle turnaround gap between owners and a bounded hold time, so one PE cannot starve the others.

## Interface
- `N_PE`, default 4: number of requesting PE tiles, 2..16.
- `MAX_HOLD`, default 16: maximum grant cycles while another PE is waiting, ≥2.
- `IDW`, default `$clog2(N_PE)`: width of `grant_id`.

- `clk`  in  1  single clock domain; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `bus_request`  in  N_PE  level request per PE; bit i comes from PE i.
- `grant`  out  N_PE  one-hot or zero; bit i goes to PE i `grant`.
- `grant_id`  out  IDW  index of the current owner; valid only while `bus_busy`=1.
- `bus_busy`  out  1  high while any grant bit is high.
- `preempt`  out  1  one-cycle pulse when the owner loses the grant through timeout.

## Operation
- States: IDLE, GRANT, RELEASE. All outputs are registered and decoded from the state and owner registers.
- Priority pointer `ptr` (IDW bits): the search for the next owner starts at `ptr` and proceeds upward, wrapping at N_PE-1 to 0. The first set request bit wins.
- IDLE:
  - If any request is set, latch the winner as `owner`, clear `hold_cnt`, and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - `grant[owner]`=1, `bus_busy`=1, `grant_id`=owner.
  - `hold_cnt` increments each cycle and saturates at MAX_HOLD-1.
  - If `bus_request[owner]`=0, go to RELEASE.
  - Else if `hold_cnt`==MAX_HOLD-1 and any other request bit is set, go to RELEASE and pulse `preempt` in the first RELEASE cycle.
  - Else stay in GRANT. A lone owner keeps the grant indefinitely.
- RELEASE (exactly one cycle):
  - `grant`=0 and `bus_busy`=0. This is the bus turnaround cycle.
  - `ptr` ← (owner+1) mod N_PE.
  - Arbitration in this cycle uses the updated pointer value, (owner+1) mod N_PE. If any request is set, go to GRANT with the new winner; otherwise go to IDLE.
  - A preempted owner that keeps its request asserted re-enters the round-robin order at lowest priority.
- Requests that deassert before being granted are simply dropped; the arbiter has no request memory.
- `grant` is never multi-hot. No PE can be granted in two consecutive ownerships while another PE is requesting.

## Timing
- Reset values: state=IDLE, `ptr`=0, `owner`=0, `hold_cnt`=0, `grant`=0, `grant_id`=0, `bus_busy`=0, `preempt`=0.
- Reset during GRANT: `grant` is 0 from the first edge where `reset` is sampled high. Arbitration resumes from `ptr`=0 on the first edge after `reset` falls.
- Grant latency:
  - A request sampled high at edge k in IDLE gives `grant` high after edge k.
  - Handover gap between owners is exactly one cycle, the RELEASE cycle.
- Release latency: when the owner drops its request before edge k, `grant` falls after edge k.
- Preempt:
  - The owner holds at most MAX_HOLD cycles when contended.
  - `preempt` is high for exactly the RELEASE cycle following a timeout.
- Simultaneous events: in the timeout cycle, owner release takes precedence over timeout, so `preempt` stays 0.

## Structure
- `arbiter_pkg` holds the state encoding (IDLE=2'd0, GRANT=2'd1, RELEASE=2'd2) and the default N_PE and MAX_HOLD localparams shared with the top-level PE array.
- One combinational sub-module, `rr_priority_picker` (inputs: request vector, start pointer; outputs: winner index, `any` flag), is instantiated once.
- The FSM, counters and output registers live in `bus_arbiter`.

## Test plan
- Reset, then `bus_request`=4'b0100 at cycle 2 → `grant`=4'b0100 and `grant_id`=2 at cycle 3. Drop the request at cycle 6 → `grant`=0 at cycle 7, and `ptr`=3.
- After reset, `bus_request`=4'b1111 held → grants PE0, gap, PE1, gap, PE2, gap, PE3, gap, PE0. Each PE releases after 3 cycles; one zero cycle between owners.
- MAX_HOLD=4, PE1 and PE2 both hold requests → PE1 granted 4 cycles, `preempt`=1 for one cycle, then PE2 granted 4 cycles, then PE1 again.
- MAX_HOLD=4, only PE3 requests for 20 cycles → `grant`=4'b1000 continuously and `preempt` never asserts.
- PE0 owner drops its request in the same cycle its hold counter reaches MAX_HOLD-1 while PE2 is waiting → RELEASE with `preempt`=0, then PE2 granted.
- `reset` asserted for one cycle while PE2 holds the grant with all PEs requesting → `grant`=0 the next cycle, then PE0 granted one cycle after reset deasserts.
